tile_ram_arbiter: RTL and testbench
===================================

# tile_ram_arbiter

Shares the single-port, 1-cycle-read-latency tile-map RAM between the display fetch path (drawing logic, pixel clock domain) and the game-logic CPU port. Display reads have absolute priority and are never delayed. CPU reads and writes are buffered in a 2-entry in-order queue and issued in free cycles, optionally only during blanking. A saturating starvation monitor flags CPU requests that wait too long.

## Interface
- ADDR_WIDTH, 13, tile-map address width (80x60 map of 8x8 tiles)
- DATA_WIDTH, 8, tile-map word width
- STARVE_LIMIT, 1023, wait cycles after which `cpu_starved` sets
- pix_clk  in  1  pixel clock; all logic on rising edge
- CPU_RESETN  in  1  synchronous, active-low reset
- display_enabled  in  1  high during visible area (from vga_signal_gen)
- blank_only  in  1  when high, CPU requests issue only while display_enabled=0
- disp_req  in  1  display read request this cycle
- disp_addr  in  ADDR_WIDTH  display read address
- disp_rvalid  out  1  disp_rdata valid (1 cycle after granted disp_req)
- disp_rdata  out  DATA_WIDTH  display read data
- cpu_req_valid  in  1  CPU request valid
- cpu_req_ready  out  1  queue can accept (not full)
- cpu_req_we  in  1  1 = write, 0 = read
- cpu_req_addr  in  ADDR_WIDTH  CPU address
- cpu_req_wdata  in  DATA_WIDTH  CPU write data
- cpu_rsp_valid  out  1  CPU read data valid, one pulse per read
- cpu_rsp_data  out  DATA_WIDTH  CPU read data
- cpu_starved  out  1  sticky; set when wait count reaches STARVE_LIMIT
- starve_clear  in  1  clears cpu_starved and wait counter
- ram_en, ram_we  out  1 each  RAM enable / write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid cycle after ram_en & ~ram_we

## Operation
- Queue: 2-entry FIFO of {we, addr, wdata}. Push on cpu_req_valid & cpu_req_ready. cpu_req_ready = ~full. No same-cycle pass-through when full, even if a pop occurs. Order is strictly preserved, so write-then-read to one address returns the new data.
- Issue per cycle, in priority order:
  - disp_req=1: RAM gets the display read (ram_en=1, ram_we=0, ram_addr=disp_addr).
  - else if queue non-empty and (~blank_only | ~display_enabled): pop head, drive RAM with it.
  - else ram_en=0.
- Combinational issue outputs: ram_* driven combinationally from the issue decision.
- Response tags are registered: disp_pend and cpu_rd_pend.
  - Next cycle: disp_rvalid = disp_pend and cpu_rsp_valid = cpu_rd_pend.
  - Both data outputs = ram_rdata. At most one is high per cycle.
- Writes produce no response.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle the queue is non-empty and no pop occurs. Resets to 0 on any pop.
  - cpu_starved sets when the counter equals STARVE_LIMIT and stays set until starve_clear or reset.
  - starve_clear takes priority over a same-cycle set.
- Counter width: $clog2(STARVE_LIMIT+1).

## Timing
- Reset (CPU_RESETN=0 at an edge): queue emptied, pend tags cleared, counter=0, cpu_starved=0.
  - While reset is held: cpu_req_ready=0, ram_en=0.
  - First cycle after release: disp_rvalid=0, cpu_rsp_valid=0. A read in flight when reset asserts is dropped and gets no response.
- Display latency: disp_req at cycle N, disp_rvalid and data at N+1. This holds regardless of queue state.
- CPU latency, idle system: accepted at N, issued at N+1, cpu_rsp_valid at N+2.
- Empty queue with push, no pop: accepted word appears at head next cycle.
- Full queue with simultaneous pop and cpu_req_valid: no push. ready rises the following cycle.
- Push and pop with 1 entry held: occupancy stays 1.
- Continuous disp_req: CPU is fully blocked and the counter saturates. Display is unaffected.
- Timing of blank_only changes: a change takes effect on the same cycle's issue decision.

## Test plan
- Reset, then CPU write 0x2A to addr 100 followed by a read of addr 100: write issues at cycle 1, read at cycle 2, cpu_rsp_valid with 0x2A at cycle 3. disp_rvalid stays 0 throughout.
- disp_req held every cycle for 20 cycles while CPU pushes 3 requests: the first 2 are accepted and the 3rd stalls (ready=0). No CPU RAM access occurs and each disp_rvalid follows its disp_req by 1 cycle. After disp_req drops, the queue drains in 2 consecutive cycles.
- blank_only=1, display_enabled=1, CPU read queued: no issue. When display_enabled falls at cycle N, ram_en=1 with the CPU address at N and cpu_rsp_valid at N+1.
- Set STARVE_LIMIT=4 and block the CPU with disp_req for 6 cycles: cpu_starved rises after the 4th wait cycle and stays high after drain. starve_clear drops it the next cycle.
- Reset asserted the cycle after a CPU read issues: no cpu_rsp_valid, queue empty, cpu_req_ready=1 one cycle after release.

Source files
------------

// File: rtl/tile_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tile_ram_arbiter
//
// Purpose:
//   Shares the single-port tile-map RAM (1-cycle read latency) between the
//   display fetch path and the game-logic CPU. Display reads always win and are
//   never delayed. CPU reads/writes sit in a 2-entry in-order queue and are
//   issued in free cycles, optionally only while the display is blanking.
//   A saturating wait counter flags CPU requests that wait too long.
//
// Ports:
//   pix_clk, CPU_RESETN          clock (rising edge), synchronous active-low reset
//   display_enabled, blank_only  visible-area flag and "CPU only in blanking" mode
//   disp_req/disp_addr           display read request
//   disp_rvalid/disp_rdata       display read data, one cycle after the request
//   cpu_req_*                    CPU request channel (valid/ready, we, addr, wdata)
//   cpu_rsp_valid/cpu_rsp_data   CPU read data, one pulse per read
//   cpu_starved, starve_clear    sticky starvation flag and its clear
//   ram_en/we/addr/wdata/rdata   single-port RAM interface
// -----------------------------------------------------------------------------
module tile_ram_arbiter #(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 1023
) (
    input  logic                  pix_clk,
    input  logic                  CPU_RESETN,
    input  logic                  display_enabled,
    input  logic                  blank_only,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_rvalid,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rsp_data,
    output logic                  cpu_starved,
    input  logic                  starve_clear,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic                  q_we    [2];
    logic [ADDR_WIDTH-1:0] q_addr  [2];
    logic [DATA_WIDTH-1:0] q_wdata [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            q_count;

    logic                  q_empty;
    logic                  q_full;
    logic                  push;
    logic                  pop;
    logic                  disp_grant;
    logic                  disp_pend;
    logic                  cpu_rd_pend;
    logic [CNT_W-1:0]      wait_cnt;
    logic [CNT_W-1:0]      wait_cnt_next;

    // Queue status and handshake. Everything that reaches the RAM or accepts a
    // request is gated by reset so that nothing moves while reset is held.
    // Ready depends only on the registered fill level, so a full queue never
    // accepts in the same cycle as a pop.
    assign q_empty       = (q_count == 2'd0);
    assign q_full        = (q_count == 2'd2);
    assign cpu_req_ready = CPU_RESETN & ~q_full;
    assign push          = cpu_req_valid & cpu_req_ready;

    // Issue decision: display first, then the queue head when the blanking
    // policy allows it. blank_only and display_enabled act in the same cycle.
    assign disp_grant = CPU_RESETN & disp_req;
    assign pop        = CPU_RESETN & ~disp_req & ~q_empty & (~blank_only | ~display_enabled);

    // Drive the RAM straight from the issue decision so a granted access
    // happens in the cycle it was decided.
    always_comb begin
        ram_en    = disp_grant | pop;
        ram_we    = pop & q_we[rd_ptr];
        ram_addr  = disp_grant ? disp_addr : q_addr[rd_ptr];
        ram_wdata = q_wdata[rd_ptr];
    end

    // Queue payload storage. It needs no reset because the pointers and the
    // fill count decide which slots are meaningful.
    always_ff @(posedge pix_clk) begin
        if (push) begin
            q_we[wr_ptr]    <= cpu_req_we;
            q_addr[wr_ptr]  <= cpu_req_addr;
            q_wdata[wr_ptr] <= cpu_req_wdata;
        end
    end

    // Queue pointers and fill level. A push and a pop in the same cycle leave
    // the occupancy unchanged.
    always_ff @(posedge pix_clk) begin
        if (!CPU_RESETN) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            q_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 2'd1;
                2'b01:   q_count <= q_count - 2'd1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Response tags remember who owns the read data coming back next cycle.
    // Writes never set a tag, so they produce no response.
    always_ff @(posedge pix_clk) begin
        if (!CPU_RESETN) begin
            disp_pend   <= 1'b0;
            cpu_rd_pend <= 1'b0;
        end else begin
            disp_pend   <= disp_grant;
            cpu_rd_pend <= pop & ~q_we[rd_ptr];
        end
    end

    // Reads that were in flight when reset arrives are dropped, so the
    // valids are also masked while reset is held.
    assign disp_rvalid   = CPU_RESETN & disp_pend;
    assign cpu_rsp_valid = CPU_RESETN & cpu_rd_pend;
    assign disp_rdata    = ram_rdata;
    assign cpu_rsp_data  = ram_rdata;

    // Wait counter: counts cycles where work is queued but nothing is popped,
    // saturating at the limit, and restarts on every pop or a clear.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (pop || starve_clear) begin
            wait_cnt_next = '0;
        end else if (!q_empty && (wait_cnt != LIMIT)) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    // Starvation flag is sticky. It sets as soon as the counter reaches the
    // limit, and a clear in the same cycle wins over the set.
    always_ff @(posedge pix_clk) begin
        if (!CPU_RESETN) begin
            wait_cnt    <= '0;
            cpu_starved <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (starve_clear) begin
                cpu_starved <= 1'b0;
            end else if (wait_cnt_next == LIMIT) begin
                cpu_starved <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tile_ram_arbiter
//
// Purpose:
//   Self-checking bench for tile_ram_arbiter. A behavioural RAM answers the
//   arbiter's accesses; unwritten words read back as pattern(addr). Expected
//   read data is queued when a request is driven and popped when the matching
//   valid appears. The instance uses STARVE_LIMIT=4 to make starvation short.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_tile_ram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int SL = 4;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } vec_t;

    logic          pix_clk = 1'b0;
    logic          CPU_RESETN;
    logic          display_enabled;
    logic          blank_only;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_req_we;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_rsp_valid;
    logic [DW-1:0] cpu_rsp_data;
    logic          cpu_starved;
    logic          starve_clear;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    bit [DW-1:0] ram_mem [1 << AW];
    bit          ram_written [1 << AW];
    logic [DW-1:0] cpu_q [$];
    logic [DW-1:0] disp_q [$];
    logic prev_disp = 1'b0;
    bit   mon_en = 1'b0;
    vec_t vecs [9];

    tile_ram_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .pix_clk         (pix_clk),
        .CPU_RESETN      (CPU_RESETN),
        .display_enabled (display_enabled),
        .blank_only      (blank_only),
        .disp_req        (disp_req),
        .disp_addr       (disp_addr),
        .disp_rvalid     (disp_rvalid),
        .disp_rdata      (disp_rdata),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_ready   (cpu_req_ready),
        .cpu_req_we      (cpu_req_we),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_wdata   (cpu_req_wdata),
        .cpu_rsp_valid   (cpu_rsp_valid),
        .cpu_rsp_data    (cpu_rsp_data),
        .cpu_starved     (cpu_starved),
        .starve_clear    (starve_clear),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
    );

    // Free-running pixel clock, 10 time units per cycle.
    always #5 pix_clk = ~pix_clk;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge pix_clk);
        #1;
    endtask

    // Offer one CPU request, optionally with random display traffic, and wait
    // (bounded) until it is accepted. Read expectations are queued on accept.
    task automatic applyStimulus(input vec_t v, input bit rand_disp);
        bit accepted;
        accepted      = 1'b0;
        cpu_req_valid = 1'b1;
        cpu_req_we    = v.we;
        cpu_req_addr  = v.addr;
        cpu_req_wdata = v.wdata;
        for (int waited = 0; waited < 64 && !accepted; waited++) begin
            if (rand_disp) begin
                disp_req  = 1'($urandom_range(0, 1));
                disp_addr = AW'(4096 + $urandom_range(0, 4095));
            end
            @(negedge pix_clk);
            if (cpu_req_ready) begin
                accepted = 1'b1;
                if (!v.we) begin
                    cpu_q.push_back(v.rdata);
                end
            end
            next_cycle();
        end
        cpu_req_valid = 1'b0;
        disp_req      = 1'b0;
        if (!accepted) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL accept_timeout: addr 0x%0h never accepted, ready stayed 0, required 1", v.addr);
        end
    endtask

    // Behavioural single-port RAM with one cycle of read latency.
    always @(posedge pix_clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr]     <= ram_wdata;
                ram_written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= ram_written[ram_addr] ? ram_mem[ram_addr] : pattern(ram_addr);
            end
        end
    end

    // Per-cycle monitor: display latency and priority, reset gating, and the
    // read-data scoreboards for both requesters.
    always @(negedge pix_clk) begin
        if (mon_en) begin
            checkOutput("disp_rvalid", disp_rvalid, prev_disp & CPU_RESETN);
            if (disp_rvalid) begin
                if (disp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL disp_unexpected: disp_rvalid=1 with no display read pending, required 0");
                end else begin
                    checkOutput("disp_rdata", disp_rdata, disp_q.pop_front());
                end
            end
            if (cpu_rsp_valid) begin
                if (cpu_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL cpu_rsp_unexpected: cpu_rsp_valid=1 data 0x%0h with no read pending, required 0", cpu_rsp_data);
                end else begin
                    checkOutput("cpu_rsp_data", cpu_rsp_data, cpu_q.pop_front());
                end
            end
            if (CPU_RESETN && disp_req) begin
                checkOutput("ram_disp_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, disp_addr});
                disp_q.push_back(pattern(disp_addr));
            end
            if (!CPU_RESETN) begin
                checkOutput("reset_ready", cpu_req_ready, 0);
                checkOutput("reset_ram_en", ram_en, 0);
            end
        end
        prev_disp = mon_en & CPU_RESETN & disp_req;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, write/read, table vectors, then the multi-cycle
    // corner cases (full queue under display load, blanking, starvation, reset).
    initial begin
        vecs[0] = '{1'b1, AW'(200), 8'h11, 8'h00};
        vecs[1] = '{1'b0, AW'(200), 8'h00, 8'h11};
        vecs[2] = '{1'b0, AW'(201), 8'h00, pattern(AW'(201))};
        vecs[3] = '{1'b1, AW'(201), 8'h22, 8'h00};
        vecs[4] = '{1'b1, AW'(201), 8'h33, 8'h00};
        vecs[5] = '{1'b0, AW'(201), 8'h00, 8'h33};
        vecs[6] = '{1'b0, AW'(300), 8'h00, pattern(AW'(300))};
        vecs[7] = '{1'b1, AW'(300), 8'hC4, 8'h00};
        vecs[8] = '{1'b0, AW'(300), 8'h00, 8'hC4};

        CPU_RESETN      = 1'b0;
        display_enabled = 1'b0;
        blank_only      = 1'b0;
        disp_req        = 1'b0;
        disp_addr       = '0;
        cpu_req_valid   = 1'b0;
        cpu_req_we      = 1'b0;
        cpu_req_addr    = '0;
        cpu_req_wdata   = '0;
        starve_clear    = 1'b0;

        next_cycle();
        mon_en = 1'b1;
        repeat (2) next_cycle();

        $display("[TB] write 0x2A to 100 then read it back");
        CPU_RESETN    = 1'b1;
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b1;
        cpu_req_addr  = AW'(100);
        cpu_req_wdata = 8'h2A;
        @(negedge pix_clk);
        checkOutput("post_reset_rsp_valid", cpu_rsp_valid, 0);
        checkOutput("post_reset_starved", cpu_starved, 0);
        checkOutput("post_reset_ready", cpu_req_ready, 1);
        checkOutput("post_reset_ram_en", ram_en, 0);
        next_cycle();
        cpu_req_we   = 1'b0;
        cpu_req_addr = AW'(100);
        cpu_q.push_back(8'h2A);
        @(negedge pix_clk);
        checkOutput("t1_write_issue", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, AW'(100), 8'h2A});
        next_cycle();
        cpu_req_valid = 1'b0;
        @(negedge pix_clk);
        checkOutput("t1_read_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, AW'(100)});
        next_cycle();
        @(negedge pix_clk);
        checkOutput("t1_rsp_valid", cpu_rsp_valid, 1);
        next_cycle();

        $display("[TB] table vectors with random display traffic");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], 1'b1);
        end
        repeat (6) next_cycle();

        $display("[TB] continuous display reads while CPU fills the queue");
        disp_req      = 1'b1;
        disp_addr     = AW'(5000);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b1;
        cpu_req_addr  = AW'(400);
        cpu_req_wdata = 8'h55;
        @(negedge pix_clk);
        checkOutput("t2_ready_empty", cpu_req_ready, 1);
        next_cycle();
        disp_addr    = AW'(5001);
        cpu_req_we   = 1'b0;
        cpu_req_addr = AW'(400);
        cpu_q.push_back(8'h55);
        @(negedge pix_clk);
        checkOutput("t2_ready_one", cpu_req_ready, 1);
        next_cycle();
        disp_addr    = AW'(5002);
        cpu_req_addr = AW'(401);
        @(negedge pix_clk);
        checkOutput("t2_ready_full", cpu_req_ready, 0);
        for (int c = 3; c < 20; c++) begin
            next_cycle();
            disp_addr = AW'(5000 + c);
            @(negedge pix_clk);
            checkOutput("t2_ready_blocked", cpu_req_ready, 0);
        end
        next_cycle();
        disp_req = 1'b0;
        @(negedge pix_clk);
        checkOutput("t2_no_passthrough", cpu_req_ready, 0);
        checkOutput("t2_drain_write", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, AW'(400), 8'h55});
        next_cycle();
        cpu_q.push_back(pattern(AW'(401)));
        @(negedge pix_clk);
        checkOutput("t2_ready_after_pop", cpu_req_ready, 1);
        checkOutput("t2_drain_read", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, AW'(400)});
        next_cycle();
        cpu_req_valid = 1'b0;
        @(negedge pix_clk);
        checkOutput("t2_third_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, AW'(401)});
        checkOutput("t2_starved", cpu_starved, 1);
        next_cycle();
        starve_clear = 1'b1;
        next_cycle();
        starve_clear = 1'b0;
        @(negedge pix_clk);
        checkOutput("t2_starve_cleared", cpu_starved, 0);
        next_cycle();

        $display("[TB] blank_only holds the CPU until display_enabled falls");
        blank_only      = 1'b1;
        display_enabled = 1'b1;
        cpu_req_valid   = 1'b1;
        cpu_req_we      = 1'b0;
        cpu_req_addr    = AW'(403);
        cpu_q.push_back(pattern(AW'(403)));
        @(negedge pix_clk);
        checkOutput("t3_ready", cpu_req_ready, 1);
        next_cycle();
        cpu_req_valid = 1'b0;
        @(negedge pix_clk);
        checkOutput("t3_held", ram_en, 0);
        repeat (2) begin
            next_cycle();
            @(negedge pix_clk);
            checkOutput("t3_held", ram_en, 0);
        end
        next_cycle();
        display_enabled = 1'b0;
        @(negedge pix_clk);
        checkOutput("t3_blank_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, AW'(403)});
        next_cycle();
        @(negedge pix_clk);
        checkOutput("t3_rsp_valid", cpu_rsp_valid, 1);
        next_cycle();
        blank_only = 1'b0;

        $display("[TB] starvation with limit 4 under six display cycles");
        disp_req      = 1'b1;
        disp_addr     = AW'(6000);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = AW'(402);
        cpu_q.push_back(pattern(AW'(402)));
        next_cycle();
        cpu_req_valid = 1'b0;
        @(negedge pix_clk);
        checkOutput("t4_starved_early", cpu_starved, 0);
        repeat (3) next_cycle();
        @(negedge pix_clk);
        checkOutput("t4_starved_after3", cpu_starved, 0);
        next_cycle();
        @(negedge pix_clk);
        checkOutput("t4_starved_after4", cpu_starved, 1);
        next_cycle();
        disp_req = 1'b0;
        @(negedge pix_clk);
        checkOutput("t4_drain_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, AW'(402)});
        checkOutput("t4_sticky_drain", cpu_starved, 1);
        next_cycle();
        @(negedge pix_clk);
        checkOutput("t4_sticky_after", cpu_starved, 1);
        next_cycle();
        starve_clear = 1'b1;
        @(negedge pix_clk);
        checkOutput("t4_clear_not_yet", cpu_starved, 1);
        next_cycle();
        starve_clear = 1'b0;
        @(negedge pix_clk);
        checkOutput("t4_cleared", cpu_starved, 0);
        next_cycle();

        $display("[TB] reset right after a CPU read issues");
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = AW'(404);
        @(negedge pix_clk);
        checkOutput("t5_ready", cpu_req_ready, 1);
        next_cycle();
        cpu_req_we    = 1'b1;
        cpu_req_addr  = AW'(405);
        cpu_req_wdata = 8'h77;
        @(negedge pix_clk);
        checkOutput("t5_read_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, AW'(404)});
        next_cycle();
        cpu_req_valid = 1'b0;
        CPU_RESETN    = 1'b0;
        @(negedge pix_clk);
        checkOutput("t5_rsp_dropped", cpu_rsp_valid, 0);
        next_cycle();
        CPU_RESETN = 1'b1;
        @(negedge pix_clk);
        checkOutput("t5_rsp_after_release", cpu_rsp_valid, 0);
        checkOutput("t5_ready_after_release", cpu_req_ready, 1);
        checkOutput("t5_queue_flushed", ram_en, 0);
        checkOutput("t5_starved_after_release", cpu_starved, 0);

        repeat (5) next_cycle();
        checkOutput("cpu_q_drained", cpu_q.size(), 0);
        checkOutput("disp_q_drained", disp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
